// File: rtl/transfer_sequencer.sv
// Control sequencer for the DataTransfer datapath: takes 16-bit instructions over a
// valid/ready handshake and plays out the registered strobe sequence for each one.
module transfer_sequencer #(
  parameter int unsigned AW    = 5,
  parameter int unsigned DW    = 8,
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [15:0]      instr,
  input  logic             instr_valid,
  output logic             instr_ready,
  output logic             WriteEnable,
  output logic [AW-1:0]    WriteAddr,
  output logic [DW-1:0]    WriteData,
  output logic [AW-1:0]    ReadAddr1,
  output logic [AW-1:0]    ReadAddr2,
  output logic             LD_A,
  output logic             LD_B,
  output logic             LD_C,
  output logic             OEA,
  output logic             OEB,
  output logic             OEC,
  output logic [1:0]       SelMux,
  output logic [2:0]       opcode,
  output logic             enableALU,
  output logic             done,
  output logic             err,
  output logic [CNT_W-1:0] instr_count
);

  typedef enum logic [2:0] {
    StIdle,
    StWrite,
    StLoadAb,
    StExec,
    StWb,
    StDrive
  } state_t;

  localparam logic [1:0] KindLdi = 2'b00;
  localparam logic [1:0] KindAlu = 2'b01;
  localparam logic [1:0] KindMov = 2'b10;

  state_t     state;
  logic [2:0] op_q;
  logic [1:0] src;

  assign src = instr[13:12];

  // Single registered FSM: state plus every output is a flop.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= StIdle;
      op_q        <= '0;
      instr_ready <= 1'b0;
      WriteEnable <= 1'b0;
      WriteAddr   <= '0;
      WriteData   <= '0;
      ReadAddr1   <= '0;
      ReadAddr2   <= '0;
      LD_A        <= 1'b0;
      LD_B        <= 1'b0;
      LD_C        <= 1'b0;
      OEA         <= 1'b0;
      OEB         <= 1'b0;
      OEC         <= 1'b0;
      SelMux      <= 2'b00;
      opcode      <= '0;
      enableALU   <= 1'b0;
      done        <= 1'b0;
      err         <= 1'b0;
      instr_count <= '0;
    end else begin
      // Strobes and pulses default low; bus released unless a MOV drives it.
      instr_ready <= 1'b0;
      WriteEnable <= 1'b0;
      LD_A        <= 1'b0;
      LD_B        <= 1'b0;
      LD_C        <= 1'b0;
      OEA         <= 1'b0;
      OEB         <= 1'b0;
      OEC         <= 1'b0;
      SelMux      <= 2'b11;
      enableALU   <= 1'b0;
      done        <= 1'b0;
      err         <= 1'b0;

      case (state)
        StIdle: begin
          instr_ready <= 1'b1;
          if (instr_valid && instr_ready) begin
            unique case (instr[15:14])
              KindLdi: begin
                state       <= StWrite;
                instr_ready <= 1'b0;
                WriteEnable <= 1'b1;
                WriteAddr   <= instr[8 +: AW];
                WriteData   <= instr[0 +: DW];
              end
              KindAlu: begin
                state       <= StLoadAb;
                instr_ready <= 1'b0;
                ReadAddr1   <= instr[6 +: AW];
                ReadAddr2   <= instr[1 +: AW];
                LD_A        <= 1'b1;
                LD_B        <= 1'b1;
                op_q        <= instr[13:11];
              end
              KindMov: begin
                if (src == 2'b11) begin
                  err <= 1'b1;
                end else begin
                  state       <= StDrive;
                  instr_ready <= 1'b0;
                  SelMux      <= src;
                  OEA         <= (src == 2'b00);
                  OEB         <= (src == 2'b01);
                  OEC         <= (src == 2'b10);
                end
              end
              default: begin
                // NOP retires in place; any nonzero [13:11] makes it illegal.
                if (instr[13:11] == 3'b000) begin
                  done        <= 1'b1;
                  instr_count <= instr_count + CNT_W'(1);
                end else begin
                  err <= 1'b1;
                end
              end
            endcase
          end
        end
        StLoadAb: begin
          state     <= StExec;
          OEA       <= 1'b1;
          OEB       <= 1'b1;
          enableALU <= 1'b1;
          opcode    <= op_q;
        end
        StExec: begin
          state     <= StWb;
          OEA       <= 1'b1;
          OEB       <= 1'b1;
          enableALU <= 1'b1;
          LD_C      <= 1'b1;
        end
        StWrite, StDrive, StWb: begin
          state       <= StIdle;
          instr_ready <= 1'b1;
          done        <= 1'b1;
          instr_count <= instr_count + CNT_W'(1);
        end
        default: begin
          state       <= StIdle;
          instr_ready <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_transfer_sequencer.sv
// Self-checking bench for transfer_sequencer: a per-instruction cycle-trace model
// built from the instruction rules feeds an expected-output queue.
`timescale 1ns/1ps
module tb_transfer_sequencer;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [15:0] instr = '0;
  logic        instr_valid = 1'b0;
  logic        instr_ready;
  logic        WriteEnable;
  logic [4:0]  WriteAddr;
  logic [7:0]  WriteData;
  logic [4:0]  ReadAddr1;
  logic [4:0]  ReadAddr2;
  logic        LD_A, LD_B, LD_C, OEA, OEB, OEC;
  logic [1:0]  SelMux;
  logic [2:0]  opcode;
  logic        enableALU;
  logic        done;
  logic        err;
  logic [15:0] instr_count;

  transfer_sequencer dut (
    .clk(clk), .rst(rst), .instr(instr), .instr_valid(instr_valid),
    .instr_ready(instr_ready), .WriteEnable(WriteEnable), .WriteAddr(WriteAddr),
    .WriteData(WriteData), .ReadAddr1(ReadAddr1), .ReadAddr2(ReadAddr2),
    .LD_A(LD_A), .LD_B(LD_B), .LD_C(LD_C), .OEA(OEA), .OEB(OEB), .OEC(OEC),
    .SelMux(SelMux), .opcode(opcode), .enableALU(enableALU), .done(done),
    .err(err), .instr_count(instr_count)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        ready;
    logic        we;
    logic [4:0]  wa;
    logic [7:0]  wd;
    logic [4:0]  ra1;
    logic [4:0]  ra2;
    logic        lda, ldb, ldc;
    logic        oea, oeb, oec;
    logic [1:0]  sel;
    logic [2:0]  op;
    logic        en;
    logic        done;
    logic        err;
    logic [15:0] count;
  } obs_t;

  int tests  = 0;
  int failed = 0;

  // Model state: values that hold between strobes, the count, and expected ready.
  logic [4:0]  m_wa, m_ra1, m_ra2;
  logic [7:0]  m_wd;
  logic [2:0]  m_op;
  logic [15:0] m_count;
  bit          m_ready;
  obs_t        exp_q[$];
  obs_t        exp_cur;

  function automatic obs_t obs();
    obs_t o;
    o.ready = instr_ready; o.we = WriteEnable; o.wa = WriteAddr; o.wd = WriteData;
    o.ra1 = ReadAddr1; o.ra2 = ReadAddr2; o.lda = LD_A; o.ldb = LD_B; o.ldc = LD_C;
    o.oea = OEA; o.oeb = OEB; o.oec = OEC; o.sel = SelMux; o.op = opcode;
    o.en = enableALU; o.done = done; o.err = err; o.count = instr_count;
    return o;
  endfunction

  function automatic obs_t idle_e();
    obs_t e = '0;
    e.ready = 1'b1; e.sel = 2'b11;
    e.wa = m_wa; e.wd = m_wd; e.ra1 = m_ra1; e.ra2 = m_ra2; e.op = m_op;
    e.count = m_count;
    return e;
  endfunction

  task automatic model_reset();
    m_wa = '0; m_wd = '0; m_ra1 = '0; m_ra2 = '0; m_op = '0; m_count = '0;
    m_ready = 1'b1;
    exp_q.delete();
  endtask

  task automatic retire();
    obs_t e;
    m_count = m_count + 16'd1;
    e = idle_e(); e.done = 1'b1;
    exp_q.push_back(e);
  endtask

  // Expected cycle-by-cycle trace for one accepted instruction, starting at the accept edge.
  task automatic plan(input logic [15:0] ins);
    obs_t e;
    case (ins[15:14])
      2'b00: begin
        m_wa = ins[12:8]; m_wd = ins[7:0];
        e = idle_e(); e.ready = 1'b0; e.we = 1'b1; exp_q.push_back(e);
        retire();
      end
      2'b01: begin
        m_ra1 = ins[10:6]; m_ra2 = ins[5:1];
        e = idle_e(); e.ready = 1'b0; e.lda = 1'b1; e.ldb = 1'b1; exp_q.push_back(e);
        m_op = ins[13:11];
        e = idle_e(); e.ready = 1'b0; e.oea = 1'b1; e.oeb = 1'b1; e.en = 1'b1;
        exp_q.push_back(e);
        e.ldc = 1'b1; exp_q.push_back(e);
        retire();
      end
      2'b10: begin
        if (ins[13:12] == 2'b11) begin
          e = idle_e(); e.err = 1'b1; exp_q.push_back(e);
        end else begin
          e = idle_e(); e.ready = 1'b0; e.sel = ins[13:12];
          e.oea = (ins[13:12] == 2'b00);
          e.oeb = (ins[13:12] == 2'b01);
          e.oec = (ins[13:12] == 2'b10);
          exp_q.push_back(e);
          retire();
        end
      end
      default: begin
        if (ins[13:11] == 3'b000) retire();
        else begin
          e = idle_e(); e.err = 1'b1; exp_q.push_back(e);
        end
      end
    endcase
  endtask

  // One clock of stimulus: present the pending instruction (held while busy), or idle.
  task automatic tick(input bit have, input logic [15:0] ins, input bit gap, output bit taken);
    taken = 1'b0;
    if (have && !(gap && m_ready)) begin
      instr = ins; instr_valid = 1'b1;
      if (m_ready) begin
        plan(ins);
        taken = 1'b1;
      end
    end else begin
      instr_valid = 1'b0; instr = 16'($urandom);
      if (m_ready) exp_q.push_back(idle_e());
    end
    @(posedge clk); #1;
    exp_cur = (exp_q.size() != 0) ? exp_q.pop_front() : idle_e();
    m_ready = exp_cur.ready;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk); rst = 1'b1;
    @(posedge clk); #1;
    model_reset();
  endtask

  task automatic test_reset();
    bit tk;
    rst = 1'b0; instr = 16'h03A5; instr_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      tests++;
      if (obs() !== obs_t'('0)) begin
        failed++; $display("FAIL reset_hold: got %h want %h", obs(), obs_t'('0));
      end
    end
    @(negedge clk); rst = 1'b1;
    @(posedge clk); #1;
    model_reset();
    tests++;
    if (obs() !== idle_e()) begin
      failed++; $display("FAIL reset_release: got %h want %h", obs(), idle_e());
    end
    tick(1'b0, 16'h0, 1'b0, tk);
    tests++;
    if (obs() !== exp_cur) begin
      failed++; $display("FAIL reset_no_accept: got %h want %h", obs(), exp_cur);
    end
  endtask

  task automatic run_named(input string name, input logic [15:0] list[$], input bit gaps);
    int k = 0;
    bit tk;
    while (k < list.size() || exp_q.size() != 0) begin
      tick(k < list.size(), (k < list.size()) ? list[k] : 16'h0,
           gaps && ($urandom_range(0, 3) == 0), tk);
      if (tk) k++;
      tests++;
      if (obs() !== exp_cur) begin
        failed++; $display("FAIL %s k=%0d: got %h want %h", name, k, obs(), exp_cur);
      end
    end
  endtask

  task automatic test_ldi();
    logic [15:0] l[$] = '{16'h03A5};
    run_named("ldi", l, 1'b0);
    tests++;
    if (instr_count !== 16'd1 || WriteAddr !== 5'd3 || WriteData !== 8'hA5) begin
      failed++;
      $display("FAIL ldi_direct: got cnt=%h wa=%h wd=%h want 0001/03/a5",
               instr_count, WriteAddr, WriteData);
    end
  endtask

  task automatic test_alu();
    logic [15:0] l[$] = '{16'h5044};
    run_named("alu", l, 1'b0);
    tests++;
    if (opcode !== 3'b010 || ReadAddr1 !== 5'd1 || ReadAddr2 !== 5'd2) begin
      failed++;
      $display("FAIL alu_direct: got op=%b ra1=%0d ra2=%0d want 010/1/2",
               opcode, ReadAddr1, ReadAddr2);
    end
  endtask

  task automatic test_mov();
    logic [15:0] l[$] = '{16'hA000, 16'hB000, 16'h8000, 16'h9000, 16'hC800};
    run_named("mov", l, 1'b0);
  endtask

  task automatic test_back_to_back();
    logic [15:0] l[$] = '{16'h5044, 16'h0112, 16'h6A3E, 16'hC000, 16'hA000};
    run_named("b2b", l, 1'b0);
  endtask

  task automatic test_random();
    logic [15:0] l[$];
    for (int i = 0; i < 60; i++) l.push_back(16'($urandom));
    run_named("random", l, 1'b1);
  endtask

  task automatic test_reset_mid();
    bit tk;
    tick(1'b1, 16'h7A8C, 1'b0, tk);
    tick(1'b1, 16'h7A8C, 1'b0, tk);
    tests++;
    if (exp_cur.en !== 1'b1 || obs() !== exp_cur) begin
      failed++; $display("FAIL rst_mid_exec: got %h want %h", obs(), exp_cur);
    end
    rst = 1'b0; #1;
    tests++;
    if (obs() !== obs_t'('0)) begin
      failed++; $display("FAIL rst_mid_async: got %h want %h", obs(), obs_t'('0));
    end
    @(posedge clk); #1;
    tests++;
    if (obs() !== obs_t'('0)) begin
      failed++; $display("FAIL rst_mid_no_done: got %h want %h", obs(), obs_t'('0));
    end
    instr_valid = 1'b0;
    @(negedge clk); rst = 1'b1;
    @(posedge clk); #1;
    model_reset();
    tests++;
    if (obs() !== idle_e()) begin
      failed++; $display("FAIL rst_mid_release: got %h want %h", obs(), idle_e());
    end
  endtask

  task automatic test_wrap();
    bit tk;
    do_reset();
    for (int i = 0; i < 65535; i++) begin
      tick(1'b1, 16'hC000, 1'b0, tk);
      if (i >= 65533) begin
        tests++;
        if (obs() !== exp_cur) begin
          failed++; $display("FAIL wrap_pre: got %h want %h", obs(), exp_cur);
        end
      end
    end
    tests++;
    if (instr_count !== 16'hFFFF) begin
      failed++; $display("FAIL wrap_ffff: got %h want ffff", instr_count);
    end
    tick(1'b1, 16'hC000, 1'b0, tk);
    tests++;
    if (instr_count !== 16'h0000 || done !== 1'b1 || obs() !== exp_cur) begin
      failed++; $display("FAIL wrap_zero: got %h want %h", obs(), exp_cur);
    end
    instr_valid = 1'b0;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    model_reset();
    test_reset();
    test_ldi();
    test_alu();
    test_mov();
    test_back_to_back();
    test_random();
    test_reset_mid();
    test_random();
    test_wrap();
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
